// File: rtl/mips_mem_pkg.sv
// Shared encodings and the load lane-extract helper for the MEM-stage data memory initiator.
package mips_mem_pkg;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Selects the addressed byte/halfword lane (little-endian) and extends it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[7:0];
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{b[7] & ~is_unsigned}}, b};
      SZ_HALF: load_extract = {{16{h[15] & ~is_unsigned}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational store merge: replaces the addressed byte/halfword lane(s) of an old word with new data.
module store_lane_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  logic [BYTES_PER_WORD-1:0] lane_en;
  logic [31:0]               lane_data;

  // Sub-word data is replicated across lanes so each enabled lane picks its slice directly.
  always_comb begin
    lane_en   = '0;
    lane_data = new_data;
    merged    = old_word;
    case (size)
      SZ_BYTE: begin
        lane_en[addr_lo] = 1'b1;
        lane_data        = {4{new_data[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{new_data[15:0]}};
      end
      default: lane_en = '1;
    endcase
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      merged[8*i +: 8] = lane_en[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory initiator: word-only memory accesses, RMW sub-word stores, extended sub-word loads.
// Define MEM_ALIGN_CHECK_EN to fault and suppress misaligned halfword/word accesses.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [1:0]               size_i,
  input  logic                     unsigned_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     stall_o,
  output logic                     misaligned_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  state_t                   state;
  logic [DATA_WIDTH-1:0]    merge_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;

  logic                  is_word;
  logic                  is_half;
  logic                  misaligned;
  logic                  idle;
  logic                  store_req;
  logic                  word_store;
  logic                  subword_store;
  logic                  load_active;
  logic [DATA_WIDTH-1:0] merged;

  // Reserved size 2'b11 shares bit 1 with SZ_WORD, so it decodes as a word.
  assign is_word = size_i[1];
  assign is_half = (size_i == SZ_HALF);
  assign idle    = (state == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = idle && (mem_read_i || mem_write_i) &&
                      ((is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign store_req     = idle && mem_write_i && !misaligned;
  assign word_store    = store_req && is_word;
  assign subword_store = store_req && !is_word;
  assign load_active   = idle && mem_read_i && !misaligned;

  store_lane_merge u_merge (
    .old_word (mem_rdata_i),
    .new_data (wdata_i),
    .size     (size_i),
    .addr_lo  (addr_i[1:0]),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (subword_store) begin
            addr_q  <= addr_i;
            merge_q <= merged;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Write enable is gated by reset so a reset landing on the WRITE cycle drops the pending write.
  always_comb begin
    mem_addr_o  = addr_i;
    mem_wdata_o = wdata_i;
    mem_we_o    = 1'b0;
    stall_o     = 1'b0;
    if (state == ST_WRITE) begin
      mem_addr_o  = addr_q;
      mem_wdata_o = merge_q;
      mem_we_o    = !rst;
    end else begin
      mem_we_o = word_store && !rst;
      stall_o  = subword_store && !rst;
    end
  end

  assign misaligned_o = misaligned && !rst;
  assign rdata_o      = load_active ? load_extract(mem_rdata_i, size_i, addr_i[1:0], unsigned_i)
                                    : '0;

endmodule
